// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester float ALU arbiter.
package alu_pkg;

    // ALU opcodes, passed through to the ALU unchecked.
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_DIV = 3'b010,
        OP_MUL = 3'b011
    } alu_op_e;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Cycles from stable operands to a valid ALU result.
    localparam int unsigned ALU_LAT_DEFAULT = 2;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way combinational round-robin grant; one-hot output.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    // A lone requester wins outright; on a tie the pointer picks the winner.
    always_comb begin
        gnt_o = valid_i;
        if (&valid_i) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked float32 ALU between two valid/ready requesters,
// one operation in flight at a time, round-robin on completion.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = ALU_LAT_DEFAULT,
    parameter int unsigned W       = 32,
    parameter int unsigned OPW     = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [OPW-1:0] req0_op,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [W-1:0]   rsp0_data,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [W-1:0]   rsp1_data,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [W-1:0]   alu_o,
    output logic           busy
);

    localparam int unsigned CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_e         state_q;
    logic           rr_ptr_q;
    logic           gnt_id_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic [W-1:0]   rsp0_data_q;
    logic [W-1:0]   rsp1_data_q;
    logic [1:0]     gnt;
    logic           rsp_take;

    rr_arb2 u_arb (
        .valid_i ({req1_valid, req0_valid}),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (gnt)
    );

    // Grants are only offered while idle; the granted requester completes on its own rsp_ready.
    always_comb begin
        req0_ready = (state_q == IDLE) && gnt[0];
        req1_ready = (state_q == IDLE) && gnt[1];
        rsp_take   = gnt_id_q ? rsp1_ready : rsp0_ready;
        rsp0_valid = (state_q == RESP) && !gnt_id_q;
        rsp1_valid = (state_q == RESP) && gnt_id_q;
        busy       = (state_q != IDLE);
        rsp0_data  = rsp0_data_q;
        rsp1_data  = rsp1_data_q;
        alu_a      = alu_a_q;
        alu_b      = alu_b_q;
        alu_op     = alu_op_q;
    end

    // Issue -> wait fixed ALU latency -> present result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            gnt_id_q    <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp0_data_q <= '0;
            rsp1_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|gnt) begin
                        if (gnt[1]) begin
                            alu_a_q  <= req1_a;
                            alu_b_q  <= req1_b;
                            alu_op_q <= req1_op;
                        end else begin
                            alu_a_q  <= req0_a;
                            alu_b_q  <= req0_b;
                            alu_op_q <= req0_op;
                        end
                        gnt_id_q <= gnt[1];
                        cnt_q    <= CW'(ALU_LAT - 1);
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        if (gnt_id_q) begin
                            rsp1_data_q <= alu_o;
                        end else begin
                            rsp0_data_q <= alu_o;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_take) begin
                        rr_ptr_q <= ~gnt_id_q;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
